// File: rtl/axil_ctrl_slave.sv
// AXI4-lite control/status register slave: ID, CTRL (start pulse + soft_en),
// W1C interrupt status, interrupt enable and a bank of RW scratch registers.
module axil_ctrl_slave #(
    parameter int          ADDR_WIDTH  = 13,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] ID_VALUE    = 32'hCA5E_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] axi4_slave_awaddr,
    input  logic                  axi4_slave_awvalid,
    output logic                  axi4_slave_awready,
    input  logic [DATA_WIDTH-1:0] axi4_slave_wdata,
    input  logic                  axi4_slave_wvalid,
    output logic                  axi4_slave_wready,
    output logic [1:0]            axi4_slave_bresp,
    output logic                  axi4_slave_bvalid,
    input  logic                  axi4_slave_bready,
    input  logic [ADDR_WIDTH-1:0] axi4_slave_araddr,
    input  logic                  axi4_slave_arvalid,
    output logic                  axi4_slave_arready,
    output logic [DATA_WIDTH-1:0] axi4_slave_rdata,
    output logic [1:0]            axi4_slave_rresp,
    output logic                  axi4_slave_rvalid,
    input  logic                  axi4_slave_rready,
    output logic                  start_pulse,
    input  logic                  done_pulse,
    output logic                  interrupt
);
    localparam int WW = ADDR_WIDTH - 2;
    typedef logic [WW-1:0] widx_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam widx_t WI_ID   = widx_t'(0);
    localparam widx_t WI_CTRL = widx_t'(1);
    localparam widx_t WI_ISR  = widx_t'(2);
    localparam widx_t WI_IER  = widx_t'(3);
    localparam widx_t WI_SCR0 = widx_t'(4);

    function automatic logic f_is_scratch(input widx_t w);
        return (w >= WI_SCR0) && (w < widx_t'(4 + NUM_SCRATCH));
    endfunction

    function automatic logic f_is_mapped(input widx_t w);
        return (w <= WI_IER) || f_is_scratch(w);
    endfunction

    logic                  r_aw_full;
    widx_t                 r_aw_widx;
    logic                  r_w_full;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_soft_en;
    logic                  r_isr_done;
    logic                  r_ier_en;
    logic                  r_start;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] r_scratch [NUM_SCRATCH];

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    widx_t                 w_wr_widx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    widx_t                 w_rd_widx;
    logic                  w_wr_ctrl;
    logic                  w_wr_isr;
    logic                  w_wr_ier;
    logic                  w_isr_next;
    logic                  w_ier_next;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [NUM_SCRATCH-1:0] w_scr_we;
    logic                  w_unused;

    assign w_aw_hs = axi4_slave_awvalid & ~r_aw_full;
    assign w_w_hs  = axi4_slave_wvalid & ~r_w_full;
    assign w_ar_hs = axi4_slave_arvalid & ~r_rvalid;

    // A handshake happening this cycle counts as a full holder, so a pair
    // arriving together commits at the same edge it is accepted.
    assign w_commit  = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & ~r_bvalid;
    assign w_wr_widx = r_aw_full ? r_aw_widx : axi4_slave_awaddr[ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_full ? r_w_data : axi4_slave_wdata;
    assign w_rd_widx = axi4_slave_araddr[ADDR_WIDTH-1:2];

    assign w_wr_ctrl = w_commit && (w_wr_widx == WI_CTRL);
    assign w_wr_isr  = w_commit && (w_wr_widx == WI_ISR);
    assign w_wr_ier  = w_commit && (w_wr_widx == WI_IER);

    // A done event arriving together with a W1C keeps the flag set.
    assign w_isr_next = done_pulse | (r_isr_done & ~(w_wr_isr & w_wr_data[0]));
    assign w_ier_next = w_wr_ier ? w_wr_data[0] : r_ier_en;

    generate
        for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scr_we
            assign w_scr_we[gi] = w_commit && (w_wr_widx == widx_t'(4 + gi));
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rd_widx)
            WI_ID:   w_rd_data = DATA_WIDTH'(ID_VALUE);
            WI_CTRL: w_rd_data = DATA_WIDTH'({r_soft_en, 1'b0});
            WI_ISR:  w_rd_data = DATA_WIDTH'(r_isr_done);
            WI_IER:  w_rd_data = DATA_WIDTH'(r_ier_en);
            default: begin
                w_rd_resp = f_is_scratch(w_rd_widx) ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (w_rd_widx == widx_t'(4 + i)) begin
                        w_rd_data = r_scratch[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_full  <= 1'b0;
            r_aw_widx  <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_soft_en  <= 1'b0;
            r_isr_done <= 1'b0;
            r_ier_en   <= 1'b0;
            r_start    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_widx <= axi4_slave_awaddr[ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= axi4_slave_wdata;
                end
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= f_is_mapped(w_wr_widx) ? RESP_OKAY : RESP_SLVERR;
            end else if (axi4_slave_bready) begin
                r_bvalid <= 1'b0;
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (axi4_slave_rready) begin
                r_rvalid <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_soft_en <= w_wr_data[1];
            end
            r_start    <= w_wr_ctrl & w_wr_data[0];
            r_isr_done <= w_isr_next;
            r_ier_en   <= w_ier_next;
            r_irq      <= w_isr_next & w_ier_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_scr_we[i]) begin
                    r_scratch[i] <= w_wr_data;
                end
            end
        end
    end

    assign axi4_slave_awready = ~r_aw_full;
    assign axi4_slave_wready  = ~r_w_full;
    assign axi4_slave_bvalid  = r_bvalid;
    assign axi4_slave_bresp   = r_bresp;
    assign axi4_slave_arready = ~r_rvalid;
    assign axi4_slave_rvalid  = r_rvalid;
    assign axi4_slave_rdata   = r_rdata;
    assign axi4_slave_rresp   = r_rresp;
    assign start_pulse        = r_start;
    assign interrupt          = r_irq;

    // Byte-lane address bits carry no meaning for full-word registers.
    assign w_unused = &{1'b0, axi4_slave_awaddr[1:0], axi4_slave_araddr[1:0]};
endmodule

// File: tb/tb_axil_ctrl_slave.sv
// Self-checking bench for axil_ctrl_slave: vector table, hand-written timing
// sequences and a randomized run against a register-map reference model.
module tb_axil_ctrl_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic        start_pulse, done_pulse, interrupt;

    always #5 clk = ~clk;

    axil_ctrl_slave dut (
        .clk                (clk),
        .reset              (reset),
        .axi4_slave_awaddr  (awaddr),
        .axi4_slave_awvalid (awvalid),
        .axi4_slave_awready (awready),
        .axi4_slave_wdata   (wdata),
        .axi4_slave_wvalid  (wvalid),
        .axi4_slave_wready  (wready),
        .axi4_slave_bresp   (bresp),
        .axi4_slave_bvalid  (bvalid),
        .axi4_slave_bready  (bready),
        .axi4_slave_araddr  (araddr),
        .axi4_slave_arvalid (arvalid),
        .axi4_slave_arready (arready),
        .axi4_slave_rdata   (rdata),
        .axi4_slave_rresp   (rresp),
        .axi4_slave_rvalid  (rvalid),
        .axi4_slave_rready  (rready),
        .start_pulse        (start_pulse),
        .done_pulse         (done_pulse),
        .interrupt          (interrupt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;

    always @(negedge clk) if (start_pulse === 1'b1) n_start++;

    // Reference model of the register map
    logic [31:0] m_scr [4];
    logic        m_soft, m_ier, m_isr;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_scr[i] = 32'h0;
        m_soft = 1'b0; m_ier = 1'b0; m_isr = 1'b0;
    endfunction

    function automatic void model_write(input logic [12:0] a, input logic [31:0] d,
                                        output logic [1:0] resp);
        int w;
        w = int'(a) >> 2;
        resp = 2'b00;
        if (w == 0) begin end
        else if (w == 1) m_soft = d[1];
        else if (w == 2) begin if (d[0]) m_isr = 1'b0; end
        else if (w == 3) m_ier = d[0];
        else if (w >= 4 && w < 8) m_scr[w-4] = d;
        else resp = 2'b10;
    endfunction

    function automatic void model_read(input logic [12:0] a, output logic [31:0] d,
                                       output logic [1:0] resp);
        int w;
        w = int'(a) >> 2;
        d = 32'h0;
        resp = 2'b00;
        if (w == 0) d = 32'hCA5E_0001;
        else if (w == 1) d = {30'b0, m_soft, 1'b0};
        else if (w == 2) d = {31'b0, m_isr};
        else if (w == 3) d = {31'b0, m_ier};
        else if (w >= 4 && w < 8) d = m_scr[w-4];
        else resp = 2'b10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic axi_write(input logic [12:0] a, input logic [31:0] d,
                             input int dly_aw, input int dly_w, output logic [1:0] resp);
        int t;
        bit aw_done, w_done, ahs, whs;
        t = 0; aw_done = 0; w_done = 0;
        awaddr = a; wdata = d; bready = 1'b1;
        while (!(aw_done && w_done) && t < 40) begin
            awvalid = !aw_done && (t >= dly_aw);
            wvalid  = !w_done && (t >= dly_w);
            ahs = awvalid && awready;
            whs = wvalid && wready;
            tick();
            t++;
            if (ahs) aw_done = 1;
            if (whs) w_done = 1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) check("wr_handshake_timeout", 32'd0, 32'd1);
        t = 0;
        while (bvalid !== 1'b1 && t < 20) begin tick(); t++; end
        check("wr_bvalid_latency", t, 0);
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        bit hs;
        t = 0; hs = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!hs && t < 20) begin hs = (arready === 1'b1); tick(); t++; end
        arvalid = 1'b0;
        if (!hs) check("rd_handshake_timeout", 32'd0, 32'd1);
        check("rd_rvalid_latency", rvalid, 1);
        d = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        logic [12:0] a;
        int          exp_starts, base_starts, k, op;

        vecs.push_back('{1'b0, 13'h000, 32'h0,         2'b00, 32'hCA5E_0001});
        vecs.push_back('{1'b1, 13'h000, 32'h1234_5678, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 13'h000, 32'h0,         2'b00, 32'hCA5E_0001});
        vecs.push_back('{1'b0, 13'h014, 32'h0,         2'b00, 32'h0});
        vecs.push_back('{1'b1, 13'h010, 32'hA5A5_A5A5, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 13'h01C, 32'h0F0F_0F0F, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 13'h010, 32'h0,         2'b00, 32'hA5A5_A5A5});
        vecs.push_back('{1'b0, 13'h01F, 32'h0,         2'b00, 32'h0F0F_0F0F});
        vecs.push_back('{1'b1, 13'h100, 32'hFFFF_FFFF, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 13'h100, 32'h0,         2'b10, 32'h0});
        vecs.push_back('{1'b0, 13'h010, 32'h0,         2'b00, 32'hA5A5_A5A5});
        vecs.push_back('{1'b0, 13'h01C, 32'h0,         2'b00, 32'h0F0F_0F0F});
        vecs.push_back('{1'b0, 13'h020, 32'h0,         2'b10, 32'h0});
        vecs.push_back('{1'b1, 13'h00C, 32'hFFFF_FFFF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 13'h00C, 32'h0,         2'b00, 32'h1});
        vecs.push_back('{1'b1, 13'h00C, 32'h0,         2'b00, 32'h0});
        vecs.push_back('{1'b0, 13'h00C, 32'h0,         2'b00, 32'h0});
        vecs.push_back('{1'b1, 13'h004, 32'h0000_0002, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 13'h004, 32'h0,         2'b00, 32'h2});
        vecs.push_back('{1'b1, 13'h004, 32'h0,         2'b00, 32'h0});
        vecs.push_back('{1'b0, 13'h008, 32'h0,         2'b00, 32'h0});

        reset = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; done_pulse = 0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;

        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_start", start_pulse, 0);
        check("rst_irq", interrupt, 0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, 0, 0, r);
                model_write(vecs[i].addr, vecs[i].data, er);
                check($sformatf("vec%0d_bresp", i), r, vecs[i].resp);
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rresp", i), r, vecs[i].resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
            end
        end

        // AW in cycle 0, W in cycle 3, response expected in cycle 4
        awaddr = 13'h010; awvalid = 1'b1; bready = 1'b0;
        check("split_awready0", awready, 1);
        tick();
        awvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("split_no_bvalid_c%0d", c), bvalid, 0);
            check($sformatf("split_awready_c%0d", c), awready, 0);
            if (c < 3) tick();
        end
        wdata = 32'hDEAD_BEEF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("split_bvalid_c4", bvalid, 1);
        check("split_bresp_c4", bresp, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("split_bvalid_cleared", bvalid, 0);
        model_write(13'h010, 32'hDEAD_BEEF, er);
        axi_read(13'h010, d, r);
        check("split_readback", d, 32'hDEAD_BEEF);

        // Interrupt set, W1C clear, and W1C colliding with a done event
        axi_write(13'h00C, 32'h1, 0, 0, r);
        model_write(13'h00C, 32'h1, er);
        check("irq_idle", interrupt, 0);
        done_pulse = 1'b1;
        tick();
        done_pulse = 1'b0;
        check("irq_set", interrupt, 1);
        m_isr = 1'b1;
        axi_read(13'h008, d, r);
        check("isr_read_set", d, 32'h1);
        awaddr = 13'h008; wdata = 32'h1; awvalid = 1; wvalid = 1; bready = 1;
        tick();
        awvalid = 0; wvalid = 0;
        check("w1c_bvalid", bvalid, 1);
        check("irq_cleared", interrupt, 0);
        tick();
        bready = 0;
        m_isr = 1'b0;
        done_pulse = 1'b1;
        tick();
        done_pulse = 1'b0;
        check("irq_set2", interrupt, 1);
        awaddr = 13'h008; wdata = 32'h1; awvalid = 1; wvalid = 1; bready = 1; done_pulse = 1;
        tick();
        awvalid = 0; wvalid = 0; done_pulse = 0;
        check("w1c_vs_set_irq", interrupt, 1);
        tick();
        bready = 0;
        m_isr = 1'b1;
        axi_read(13'h008, d, r);
        check("w1c_vs_set_isr", d, 32'h1);
        axi_write(13'h008, 32'h1, 0, 0, r);
        model_write(13'h008, 32'h1, er);
        check("irq_final_clear", interrupt, 0);

        // CTRL start: one pulse per write, aligned with bvalid, independent of soft_en
        for (int j = 0; j < 2; j++) begin
            d = (j == 0) ? 32'h3 : 32'h1;
            ed = (j == 0) ? 32'h2 : 32'h0;
            base_starts = n_start;
            awaddr = 13'h004; wdata = d; awvalid = 1; wvalid = 1; bready = 1;
            check($sformatf("ctrl%0d_pulse_before", j), start_pulse, 0);
            tick();
            awvalid = 0; wvalid = 0;
            check($sformatf("ctrl%0d_pulse_with_bvalid", j), {start_pulse, bvalid}, 2'b11);
            tick();
            bready = 0;
            check($sformatf("ctrl%0d_pulse_after", j), start_pulse, 0);
            repeat (3) tick();
            check($sformatf("ctrl%0d_pulse_count", j), n_start - base_starts, 1);
            model_write(13'h004, d, er);
            axi_read(13'h004, d, r);
            check($sformatf("ctrl%0d_readback", j), d, ed);
        end

        // Read and write of the same register in the same cycle
        axi_write(13'h010, 32'h1111_1111, 0, 0, r);
        model_write(13'h010, 32'h1111_1111, er);
        araddr = 13'h010; arvalid = 1; rready = 1;
        awaddr = 13'h010; wdata = 32'h2222_2222; awvalid = 1; wvalid = 1; bready = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        check("rw_same_rvalid", rvalid, 1);
        check("rw_same_bvalid", bvalid, 1);
        check("rw_same_old_data", rdata, 32'h1111_1111);
        tick();
        rready = 0; bready = 0;
        model_write(13'h010, 32'h2222_2222, er);
        axi_read(13'h010, d, r);
        check("rw_same_new_data", d, 32'h2222_2222);

        // Backpressured response with a second pair queued behind it
        awaddr = 13'h200; wdata = 32'hFFFF_FFFF; awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awaddr = 13'h018; wdata = 32'hABCD_0123;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d_bvalid", c), bvalid, 1);
            check($sformatf("hold%0d_bresp", c), bresp, 2'b10);
            if (c >= 1) begin
                check($sformatf("hold%0d_aw_full", c), {awready, wready}, 2'b00);
            end
            tick();
            awvalid = 0; wvalid = 0;
        end
        model_read(13'h018, ed, er);
        axi_read(13'h018, d, r);
        check("hold_second_not_committed", d, ed);
        check("hold_bvalid_after_read", bvalid, 1);
        bready = 1;
        tick();
        bready = 0;
        check("hold_release_gap", bvalid, 0);
        tick();
        check("hold_second_bvalid", bvalid, 1);
        check("hold_second_bresp", bresp, 0);
        check("hold_holders_empty", {awready, wready}, 2'b11);
        bready = 1;
        tick();
        bready = 0;
        model_write(13'h018, 32'hABCD_0123, er);
        axi_read(13'h018, d, r);
        check("hold_second_readback", d, 32'hABCD_0123);

        // Reset in the middle of pending write and read responses
        axi_write(13'h00C, 32'h1, 0, 0, r);
        done_pulse = 1; tick(); done_pulse = 0;
        awaddr = 13'h014; wdata = 32'h5; awvalid = 1; wvalid = 1; bready = 0;
        araddr = 13'h010; arvalid = 1; rready = 0;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("midrst_pre_valids", {bvalid, rvalid, interrupt}, 3'b111);
        #2 reset = 1'b1;
        #1;
        check("midrst_bvalid", bvalid, 0);
        check("midrst_rvalid", rvalid, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_irq", interrupt, 0);
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        check("midrst_readies", {awready, wready, arready}, 3'b111);
        for (int i = 1; i < 8; i++) begin
            a = 13'(i * 4);
            model_read(a, ed, er);
            axi_read(a, d, r);
            check($sformatf("midrst_reg_0x%0h", a), d, ed);
        end

        // Randomized traffic against the reference model
        base_starts = n_start;
        exp_starts = 0;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            k = $urandom_range(0, 9);
            if (k < 8) a = 13'(k * 4 + $urandom_range(0, 3));
            else a = 13'($urandom_range(32, 8191));
            if (op <= 3) begin
                d = $urandom;
                axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), r);
                model_write(a, d, er);
                if ((a >> 2) == 13'd1 && d[0]) exp_starts++;
                check($sformatf("rnd%0d_bresp_0x%0h", n, a), r, er);
            end else if (op <= 7) begin
                axi_read(a, d, r);
                model_read(a, ed, er);
                check($sformatf("rnd%0d_rresp_0x%0h", n, a), r, er);
                check($sformatf("rnd%0d_rdata_0x%0h", n, a), d, ed);
            end else if (op == 8) begin
                done_pulse = 1; tick(); done_pulse = 0;
                m_isr = 1'b1;
            end else begin
                tick();
            end
            check($sformatf("rnd%0d_irq", n), interrupt, m_isr & m_ier);
        end
        repeat (2) tick();
        check("rnd_start_count", n_start - base_starts, exp_starts);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
